// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared constants for the ID/EX pipeline stage
// Halt FSM encodings, ecall halt constants and small decode helpers.
package id_ex_stage_pkg;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam int         ECALL_HALT_VALUE = 10;
  localparam logic [4:0] ECALL_ARG_REG    = 5'd17;

  typedef struct packed {
    logic wb_enable;
    logic mem_enable;
    logic mem_write;
    logic op2_imm;
    logic is_ecall;
  } ctrl_t;

  function automatic logic is_load(input logic mem_enable, input logic mem_write,
                                   input logic wb_enable);
    return mem_enable & ~mem_write & wb_enable;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID-side inputs and EX-side outputs of the ID/EX stage
// The stage uses the slave modport; the decode/driver side uses master.
interface id_ex_stage_if #(
  parameter int XLEN = 32
);
  logic            id_valid;
  logic            id_wb_enable;
  logic            id_mem_enable;
  logic            id_mem_write;
  logic            id_op2_imm;
  logic            id_is_ecall;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [3:0]      id_alu_ctrl;
  logic            flush_ex;

  logic            ex_valid;
  logic            ex_wb_enable;
  logic            ex_mem_enable;
  logic            ex_mem_write;
  logic            ex_op2_imm;
  logic            ex_is_ecall;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [3:0]      ex_alu_ctrl;
  logic            stall_if_id;
  logic            halted;
  logic [31:0]     bubble_count;

  modport master (
    output id_valid, id_wb_enable, id_mem_enable, id_mem_write, id_op2_imm, id_is_ecall,
           id_rs1, id_rs2, id_rd, id_pc, id_rs1_data, id_rs2_data, id_imm, id_alu_ctrl,
           flush_ex,
    input  ex_valid, ex_wb_enable, ex_mem_enable, ex_mem_write, ex_op2_imm, ex_is_ecall,
           ex_rd, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_alu_ctrl,
           stall_if_id, halted, bubble_count
  );

  modport slave (
    input  id_valid, id_wb_enable, id_mem_enable, id_mem_write, id_op2_imm, id_is_ecall,
           id_rs1, id_rs2, id_rd, id_pc, id_rs1_data, id_rs2_data, id_imm, id_alu_ctrl,
           flush_ex,
    output ex_valid, ex_wb_enable, ex_mem_enable, ex_mem_write, ex_op2_imm, ex_is_ecall,
           ex_rd, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_alu_ctrl,
           stall_if_id, halted, bubble_count
  );
endinterface

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard detection
// Flags an ID instruction that reads the destination of a load sitting in EX.
module hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic       i_ex_valid,
  input  logic       i_ex_mem_enable,
  input  logic       i_ex_mem_write,
  input  logic       i_ex_wb_enable,
  input  logic [4:0] i_ex_rd,
  input  logic       i_id_valid,
  input  logic       i_id_is_ecall,
  input  logic       i_id_op2_imm,
  input  logic       i_id_mem_write,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  output logic       o_load_use
);
  logic [4:0] w_src1;
  logic       w_src1_hit;
  logic       w_src2_hit;
  logic       w_ex_load;

  // ecall reads its argument register implicitly, not the encoded rs1 field
  assign w_src1     = i_id_is_ecall ? ECALL_ARG_REG : i_id_rs1;
  assign w_src1_hit = (w_src1 == i_ex_rd);
  // rs2 is a real source for register-register ops and for store data
  assign w_src2_hit = (i_id_rs2 == i_ex_rd) & (~i_id_op2_imm | i_id_mem_write);
  assign w_ex_load  = i_ex_valid & is_load(i_ex_mem_enable, i_ex_mem_write, i_ex_wb_enable)
                    & (i_ex_rd != 5'd0);

  assign o_load_use = w_ex_load & i_id_valid & (w_src1_hit | w_src2_hit);
endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubbling and ecall halt
// Owns the EX register, the bubble counter and the RUN/DRAIN/HALTED sequencer.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int HALT_DRAIN = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  id_ex_stage_if.slave  bus
);
  localparam int             CW         = (HALT_DRAIN > 1) ? $clog2(HALT_DRAIN) : 1;
  localparam logic [CW-1:0]  DRAIN_LOAD = CW'(HALT_DRAIN - 1);

  logic [1:0]      r_state;
  logic [CW-1:0]   r_drain_cnt;
  logic            r_valid;
  ctrl_t           r_ctrl;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [3:0]      r_alu_ctrl;
  logic [31:0]     r_bubble_count;

  logic w_load_use;
  logic w_run;
  logic w_halt_req;
  logic w_bubble;

  hazard_detect u_hazard_detect (
    .i_ex_valid      (r_valid),
    .i_ex_mem_enable (r_ctrl.mem_enable),
    .i_ex_mem_write  (r_ctrl.mem_write),
    .i_ex_wb_enable  (r_ctrl.wb_enable),
    .i_ex_rd         (r_rd),
    .i_id_valid      (bus.id_valid),
    .i_id_is_ecall   (bus.id_is_ecall),
    .i_id_op2_imm    (bus.id_op2_imm),
    .i_id_mem_write  (bus.id_mem_write),
    .i_id_rs1        (bus.id_rs1),
    .i_id_rs2        (bus.id_rs2),
    .o_load_use      (w_load_use)
  );

  assign w_run      = (r_state == ST_RUN);
  assign w_halt_req = r_valid & r_ctrl.is_ecall & (r_rs1_data == XLEN'(ECALL_HALT_VALUE));
  assign w_bubble   = ~w_run | bus.flush_ex | w_load_use;

  // Bubbles clear only valid/control; data fields hold their last value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid    <= 1'b0;
      r_ctrl     <= '0;
      r_rd       <= '0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_alu_ctrl <= '0;
    end else if (w_bubble) begin
      r_valid    <= 1'b0;
      r_ctrl     <= '0;
    end else begin
      r_valid    <= bus.id_valid;
      r_ctrl     <= '{wb_enable:  bus.id_wb_enable,
                      mem_enable: bus.id_mem_enable,
                      mem_write:  bus.id_mem_write,
                      op2_imm:    bus.id_op2_imm,
                      is_ecall:   bus.id_is_ecall};
      r_rd       <= bus.id_rd;
      r_pc       <= bus.id_pc;
      r_rs1_data <= bus.id_rs1_data;
      r_rs2_data <= bus.id_rs2_data;
      r_imm      <= bus.id_imm;
      r_alu_ctrl <= bus.id_alu_ctrl;
    end
  end

  // A flush already squashes the instruction, so that bubble is not a load-use one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bubble_count <= '0;
    end else if (w_run & ~bus.flush_ex & w_load_use) begin
      r_bubble_count <= r_bubble_count + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_halt_req) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == '0) begin
            r_state <= ST_HALTED;
          end else begin
            r_drain_cnt <= r_drain_cnt - 1'b1;
          end
        end
        ST_HALTED: r_state <= ST_HALTED;
        default:   r_state <= ST_RUN;
      endcase
    end
  end

  assign bus.ex_valid      = r_valid;
  assign bus.ex_wb_enable  = r_ctrl.wb_enable;
  assign bus.ex_mem_enable = r_ctrl.mem_enable;
  assign bus.ex_mem_write  = r_ctrl.mem_write;
  assign bus.ex_op2_imm    = r_ctrl.op2_imm;
  assign bus.ex_is_ecall   = r_ctrl.is_ecall;
  assign bus.ex_rd         = r_rd;
  assign bus.ex_pc         = r_pc;
  assign bus.ex_rs1_data   = r_rs1_data;
  assign bus.ex_rs2_data   = r_rs2_data;
  assign bus.ex_imm        = r_imm;
  assign bus.ex_alu_ctrl   = r_alu_ctrl;
  assign bus.stall_if_id   = w_load_use | ~w_run;
  assign bus.halted        = (r_state == ST_HALTED);
  assign bus.bubble_count  = r_bubble_count;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
// Directed scenarios plus randomized traffic against a behavioural pipeline model.
module tb_id_ex_stage;
  localparam int XLEN       = 32;
  localparam int HALT_DRAIN = 2;
  localparam int EXW        = 1 + 5 + 5 + 4 * XLEN + 4;

  // control vector order: wb, mem, mem_write, op2_imm, ecall
  localparam logic [4:0] C_NOP   = 5'b00000;
  localparam logic [4:0] C_LOAD  = 5'b11010;
  localparam logic [4:0] C_ADD   = 5'b10000;
  localparam logic [4:0] C_ADDI  = 5'b10010;
  localparam logic [4:0] C_STORE = 5'b01110;
  localparam logic [4:0] C_ECALL = 5'b00011;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(XLEN)) bus ();

  id_ex_stage #(.XLEN(XLEN), .HALT_DRAIN(HALT_DRAIN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  wire [EXW-1:0] w_dut_ex = {bus.ex_valid, bus.ex_wb_enable, bus.ex_mem_enable, bus.ex_mem_write,
                             bus.ex_op2_imm, bus.ex_is_ecall, bus.ex_rd, bus.ex_pc,
                             bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_imm, bus.ex_alu_ctrl};

  int tests = 0;
  int fails = 0;

  // Reference model: what EX should hold, plus cycles left until halt (-1 = running)
  logic            m_valid;
  logic [4:0]      m_c;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_pc, m_rs1d, m_rs2d, m_imm;
  logic [3:0]      m_alu;
  logic [31:0]     m_bub;
  int              m_drain_left;

  function automatic logic [EXW-1:0] exp_ex();
    return {m_valid, m_c, m_rd, m_pc, m_rs1d, m_rs2d, m_imm, m_alu};
  endfunction

  function automatic logic m_load_use();
    logic [4:0] src1;
    logic       ex_is_load, hit1, hit2;
    ex_is_load = m_valid && m_c[4] && m_c[3] && !m_c[2] && (m_rd != 5'd0);
    src1 = bus.id_is_ecall ? 5'd17 : bus.id_rs1;
    hit1 = (src1 == m_rd);
    hit2 = (bus.id_rs2 == m_rd) && (!bus.id_op2_imm || bus.id_mem_write);
    return ex_is_load && bus.id_valid && (hit1 || hit2);
  endfunction

  function automatic logic m_stall();
    return m_load_use() || (m_drain_left >= 0);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_c = '0; m_rd = '0; m_pc = '0; m_rs1d = '0; m_rs2d = '0;
    m_imm = '0; m_alu = '0; m_bub = '0; m_drain_left = -1;
  endtask

  task automatic model_step();
    logic lu, running, halt_seen;
    lu        = m_load_use();
    running   = (m_drain_left < 0);
    halt_seen = running && m_valid && m_c[0] && (m_rs1d == 32'd10);
    if (running && !bus.flush_ex && lu) m_bub = m_bub + 32'd1;
    if (!running || bus.flush_ex || lu) begin
      m_valid = 1'b0; m_c = '0;
    end else begin
      m_valid = bus.id_valid;
      m_c     = {bus.id_wb_enable, bus.id_mem_enable, bus.id_mem_write, bus.id_op2_imm,
                 bus.id_is_ecall};
      m_rd = bus.id_rd; m_pc = bus.id_pc; m_rs1d = bus.id_rs1_data;
      m_rs2d = bus.id_rs2_data; m_imm = bus.id_imm; m_alu = bus.id_alu_ctrl;
    end
    if (halt_seen) m_drain_left = HALT_DRAIN;
    else if (!running && m_drain_left > 0) m_drain_left = m_drain_left - 1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] c, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] rs1d);
    bus.id_valid = v;
    {bus.id_wb_enable, bus.id_mem_enable, bus.id_mem_write, bus.id_op2_imm, bus.id_is_ecall} = c;
    bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
    bus.id_rs1_data = rs1d;
    bus.id_pc = $urandom; bus.id_rs2_data = $urandom; bus.id_imm = $urandom;
    bus.id_alu_ctrl = 4'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    bus.flush_ex = 1'b0;
  endtask

  task automatic test_reset();
    set_id(1'b1, C_LOAD, 5'd1, 5'd2, 5'd3, 32'd10);
    bus.flush_ex = 1'b0;
    model_reset();
    @(negedge clk);
    tests++; if (w_dut_ex !== '0) begin fails++; $display("FAIL reset_ex got=%h want=0", w_dut_ex); end
    tests++; if ({bus.halted, bus.stall_if_id, bus.bubble_count} !== 34'd0) begin fails++;
      $display("FAIL reset_status halted=%b stall=%b bub=%0d want 0/0/0", bus.halted, bus.stall_if_id, bus.bubble_count); end
    reset_n = 1'b1;
    tick();
    tests++; if (bus.ex_valid !== 1'b1) begin fails++; $display("FAIL reset_capture ex_valid=%b want=1", bus.ex_valid); end
    #2 reset_n = 1'b0;
    #1;
    tests++; if (w_dut_ex !== '0) begin fails++; $display("FAIL reset_async_ex got=%h want=0", w_dut_ex); end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1'b1, C_LOAD, 5'd1, 5'd2, 5'd5, $urandom);
    tick();
    set_id(1'b1, C_ADD, 5'd5, 5'd3, 5'd8, $urandom);
    #1;
    tests++; if (bus.stall_if_id !== 1'b1) begin fails++; $display("FAIL lu_stall got=%b want=1", bus.stall_if_id); end
    tick();
    tests++; if (bus.ex_valid !== 1'b0 || bus.bubble_count !== 32'd1) begin fails++;
      $display("FAIL lu_bubble ex_valid=%b bub=%0d want 0/1", bus.ex_valid, bus.bubble_count); end
    tests++; if (w_dut_ex !== exp_ex()) begin fails++; $display("FAIL lu_bubble_ex got=%h want=%h", w_dut_ex, exp_ex()); end
    tests++; if (bus.stall_if_id !== 1'b0) begin fails++; $display("FAIL lu_release got=%b want=0", bus.stall_if_id); end
    tick();
    tests++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd8 || bus.ex_wb_enable !== 1'b1) begin fails++;
      $display("FAIL lu_capture valid=%b rd=%0d want 1/8", bus.ex_valid, bus.ex_rd); end
    tests++; if (w_dut_ex !== exp_ex() || bus.bubble_count !== 32'd1) begin fails++;
      $display("FAIL lu_capture_ex got=%h want=%h bub=%0d", w_dut_ex, exp_ex(), bus.bubble_count); end
  endtask

  task automatic test_x0();
    do_reset();
    set_id(1'b1, C_LOAD, 5'd1, 5'd2, 5'd0, $urandom);
    tick();
    set_id(1'b1, C_ADD, 5'd0, 5'd0, 5'd9, $urandom);
    #1;
    tests++; if (bus.stall_if_id !== 1'b0) begin fails++; $display("FAIL x0_stall got=%b want=0", bus.stall_if_id); end
    tick();
    tests++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd9 || bus.bubble_count !== 32'd0) begin fails++;
      $display("FAIL x0_capture valid=%b rd=%0d bub=%0d want 1/9/0", bus.ex_valid, bus.ex_rd, bus.bubble_count); end
  endtask

  task automatic test_rs2_imm_store();
    do_reset();
    set_id(1'b1, C_LOAD, 5'd1, 5'd2, 5'd7, $urandom);
    tick();
    set_id(1'b1, C_ADDI, 5'd1, 5'd7, 5'd4, $urandom);
    #1;
    tests++; if (bus.stall_if_id !== 1'b0) begin fails++; $display("FAIL addi_stall got=%b want=0", bus.stall_if_id); end
    set_id(1'b1, C_LOAD, 5'd1, 5'd2, 5'd7, $urandom);
    tick();
    set_id(1'b1, C_STORE, 5'd2, 5'd7, 5'd0, $urandom);
    #1;
    tests++; if (bus.stall_if_id !== 1'b1) begin fails++; $display("FAIL store_stall got=%b want=1", bus.stall_if_id); end
    tick();
    tests++; if (bus.ex_valid !== 1'b0 || bus.bubble_count !== 32'd1) begin fails++;
      $display("FAIL store_bubble valid=%b bub=%0d want 0/1", bus.ex_valid, bus.bubble_count); end
  endtask

  task automatic test_flush_load_use();
    do_reset();
    set_id(1'b1, C_LOAD, 5'd1, 5'd2, 5'd5, $urandom);
    tick();
    set_id(1'b1, C_ADD, 5'd5, 5'd6, 5'd8, $urandom);
    bus.flush_ex = 1'b1;
    #1;
    tests++; if (bus.stall_if_id !== 1'b1) begin fails++; $display("FAIL flush_stall got=%b want=1", bus.stall_if_id); end
    tick();
    tests++; if (bus.ex_valid !== 1'b0 || bus.bubble_count !== 32'd0) begin fails++;
      $display("FAIL flush_bubble valid=%b bub=%0d want 0/0", bus.ex_valid, bus.bubble_count); end
    bus.flush_ex = 1'b0;
  endtask

  task automatic test_ecall_halt();
    do_reset();
    set_id(1'b1, C_ECALL, 5'd0, 5'd0, 5'd0, 32'd10);
    tick();
    set_id(1'b0, C_NOP, 5'd0, 5'd0, 5'd0, $urandom);
    #1;
    tests++; if (bus.stall_if_id !== 1'b0) begin fails++; $display("FAIL halt_pre_stall got=%b want=0", bus.stall_if_id); end
    for (int i = 0; i < HALT_DRAIN; i++) begin
      tick();
      tests++; if (bus.halted !== 1'b0 || bus.stall_if_id !== 1'b1) begin fails++;
        $display("FAIL halt_drain%0d halted=%b stall=%b want 0/1", i, bus.halted, bus.stall_if_id); end
    end
    set_id(1'b1, C_ADD, 5'd1, 5'd2, 5'd3, $urandom);
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (bus.halted !== 1'b1 || bus.stall_if_id !== 1'b1 || bus.ex_valid !== 1'b0) begin fails++;
        $display("FAIL halted%0d halted=%b stall=%b valid=%b want 1/1/0", i, bus.halted, bus.stall_if_id, bus.ex_valid); end
    end
    tests++; if (bus.halted !== (m_drain_left == 0)) begin fails++; $display("FAIL halt_model got=%b", bus.halted); end
  endtask

  task automatic test_ecall_no_halt();
    do_reset();
    set_id(1'b1, C_ECALL, 5'd0, 5'd0, 5'd0, 32'd9);
    tick();
    tests++; if (bus.ex_valid !== 1'b1 || bus.ex_is_ecall !== 1'b1) begin fails++;
      $display("FAIL ecall9_pass valid=%b ecall=%b want 1/1", bus.ex_valid, bus.ex_is_ecall); end
    set_id(1'b0, C_NOP, 5'd0, 5'd0, 5'd0, $urandom);
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++; if (bus.halted !== 1'b0 || bus.stall_if_id !== 1'b0) begin fails++;
        $display("FAIL ecall9_%0d halted=%b stall=%b want 0/0", i, bus.halted, bus.stall_if_id); end
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    set_id(1'b1, C_ECALL, 5'd0, 5'd0, 5'd0, 32'd10);
    tick();
    set_id(1'b0, C_NOP, 5'd0, 5'd0, 5'd0, $urandom);
    tick();
    tests++; if (bus.stall_if_id !== 1'b1 || bus.halted !== 1'b0) begin fails++;
      $display("FAIL drain_entry stall=%b halted=%b want 1/0", bus.stall_if_id, bus.halted); end
    #2 reset_n = 1'b0;
    #1;
    tests++; if (w_dut_ex !== '0 || {bus.halted, bus.stall_if_id, bus.bubble_count} !== 34'd0) begin fails++;
      $display("FAIL drain_reset ex=%h halted=%b stall=%b bub=%0d want all 0", w_dut_ex, bus.halted, bus.stall_if_id, bus.bubble_count); end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++; if (bus.halted !== 1'b0 || bus.stall_if_id !== 1'b0) begin fails++;
        $display("FAIL drain_after_reset%0d halted=%b stall=%b want 0/0", i, bus.halted, bus.stall_if_id); end
    end
  endtask

  task automatic test_random();
    logic       mem, mw, ec;
    logic [4:0] c;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (m_drain_left == 0 && $urandom_range(0, 3) == 0) do_reset();
      mem = 1'($urandom_range(0, 1));
      mw  = mem & 1'($urandom_range(0, 1));
      ec  = ($urandom_range(0, 15) == 0);
      c   = {mem ? ~mw : ($urandom_range(0, 3) != 0), mem, mw, 1'($urandom_range(0, 1)), ec};
      set_id($urandom_range(0, 7) != 0, c, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), (ec && $urandom_range(0, 1) == 1) ? 32'd10 : $urandom);
      bus.flush_ex = ($urandom_range(0, 7) == 0);
      #1;
      tests++; if (bus.stall_if_id !== m_stall()) begin fails++;
        $display("FAIL rnd_stall[%0d] got=%b want=%b", n, bus.stall_if_id, m_stall()); end
      tick();
      tests++; if (w_dut_ex !== exp_ex()) begin fails++;
        $display("FAIL rnd_ex[%0d] got=%h want=%h", n, w_dut_ex, exp_ex()); end
      tests++; if (bus.halted !== (m_drain_left == 0) || bus.bubble_count !== m_bub) begin fails++;
        $display("FAIL rnd_status[%0d] halted=%b bub=%0d want %b/%0d", n, bus.halted, bus.bubble_count, m_drain_left == 0, m_bub); end
    end
    bus.flush_ex = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_use();
    test_x0();
    test_rs2_imm_store();
    test_flush_load_use();
    test_ecall_halt();
    test_ecall_no_halt();
    test_reset_mid_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
